// File: rtl/gb_cpu_pkg.sv
// Shared CPU definitions: 8-bit ALU op codes, flag bit positions (CHNZ order)
// and the 16-bit sequencer operation/state encodings.
package gb_cpu_pkg;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_ADC    = 5'b00001;
  localparam logic [4:0] ALU_SUB    = 5'b00010;
  localparam logic [4:0] ALU_SBC    = 5'b00011;
  localparam logic [4:0] ALU_COPY_A = 5'b11000;

  localparam int FLAG_C = 0;
  localparam int FLAG_H = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 3;

  typedef enum logic [1:0] {
    OP16_ADD_HL   = 2'd0,
    OP16_ADD_SP_E = 2'd1,
    OP16_INC16    = 2'd2,
    OP16_DEC16    = 2'd3
  } op16_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } alu16_state_e;

endpackage

// File: rtl/alu16_seq.sv
// 16-bit arithmetic sequenced as two passes (low byte, then high byte) through
// the CPU's shared 8-bit ALU, which the parent wires up through the alu_* ports.
module alu16_seq
  import gb_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op16,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [3:0]  flags_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [3:0]  flags_out,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [4:0]  alu_op,
  output logic [3:0]  alu_flag_in,
  input  logic [7:0]  alu_out,
  input  logic [3:0]  alu_flag_out
);

  alu16_state_e state_q;
  op16_e        op_q;
  logic [15:0]  a_q, b_q, res_q;
  logic [3:0]   fin_q, flags_q, flags_d;
  logic         lo_c_q, lo_h_q;
  logic         busy_q, done_q;

  // Only C and H come back from the byte ALU into the 16-bit flags.
  logic unused_alu_flags;
  assign unused_alu_flags = ^alu_flag_out[FLAG_Z:FLAG_N];

  always_comb begin
    alu_op      = ALU_COPY_A;
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    alu_flag_in = 4'h0;
    unique case (state_q)
      ST_LO: begin
        alu_a               = a_q[7:0];
        alu_flag_in         = fin_q;
        alu_flag_in[FLAG_C] = 1'b0;
        unique case (op_q)
          OP16_INC16: begin alu_op = ALU_ADD; alu_b = 8'h01;    end
          OP16_DEC16: begin alu_op = ALU_SUB; alu_b = 8'h01;    end
          default:    begin alu_op = ALU_ADD; alu_b = b_q[7:0]; end
        endcase
      end
      ST_HI: begin
        alu_a               = a_q[15:8];
        alu_flag_in         = fin_q;
        alu_flag_in[FLAG_C] = lo_c_q;
        alu_op              = (op_q == OP16_DEC16) ? ALU_SBC : ALU_ADC;
        unique case (op_q)
          OP16_ADD_HL:   alu_b = b_q[15:8];
          OP16_ADD_SP_E: alu_b = {8{b_q[7]}};
          default:       alu_b = 8'h00;
        endcase
      end
      default: ;
    endcase
  end

  // ADD_HL takes H/C from the high byte (bits 11/15); ADD_SP_E from the low
  // byte (bits 3/7) because e is only an 8-bit displacement.
  always_comb begin
    flags_d = fin_q;
    unique case (op_q)
      OP16_ADD_HL: begin
        flags_d[FLAG_N] = 1'b0;
        flags_d[FLAG_H] = alu_flag_out[FLAG_H];
        flags_d[FLAG_C] = alu_flag_out[FLAG_C];
      end
      OP16_ADD_SP_E: begin
        flags_d         = 4'h0;
        flags_d[FLAG_H] = lo_h_q;
        flags_d[FLAG_C] = lo_c_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP16_ADD_HL;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      fin_q   <= 4'h0;
      res_q   <= 16'h0000;
      flags_q <= 4'h0;
      lo_c_q  <= 1'b0;
      lo_h_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_LO;
            busy_q  <= 1'b1;
            op_q    <= op16_e'(op16);
            a_q     <= opa;
            b_q     <= opb;
            fin_q   <= flags_in;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LO: begin
          state_q     <= ST_HI;
          res_q[7:0]  <= alu_out;
          lo_c_q      <= alu_flag_out[FLAG_C];
          lo_h_q      <= alu_flag_out[FLAG_H];
        end
        ST_HI: begin
          state_q     <= ST_DONE;
          res_q[15:8] <= alu_out;
          flags_q     <= flags_d;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = res_q;
  assign flags_out = flags_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq: behavioural 8-bit ALU on the alu_* ports, table of
// vectors plus random ops scored through a queue, and multi-cycle corner cases.
module tb_alu16_seq;
  import gb_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op16;
  logic [15:0] opa, opb;
  logic [3:0]  flags_in;
  logic        busy, done;
  logic [15:0] result;
  logic [3:0]  flags_out;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [4:0]  alu_op;
  logic [3:0]  alu_flag_in, alu_flag_out;

  alu16_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op16(op16), .opa(opa), .opb(opb),
    .flags_in(flags_in), .busy(busy), .done(done), .result(result), .flags_out(flags_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_flag_in(alu_flag_in),
    .alu_out(alu_out), .alu_flag_out(alu_flag_out)
  );

  always #5 clk = ~clk;

  // Behavioural byte ALU, CHNZ flag order, C/H mean borrow on subtract.
  logic [8:0] m_r;
  logic [4:0] m_h;
  logic       m_c;
  always_comb begin
    m_r          = 9'h000;
    m_h          = 5'h00;
    m_c          = 1'b0;
    alu_out      = alu_a;
    alu_flag_out = alu_flag_in;
    if (alu_op == ALU_ADD || alu_op == ALU_ADC) begin
      m_c          = (alu_op == ALU_ADC) ? alu_flag_in[0] : 1'b0;
      m_r          = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, m_c};
      m_h          = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'h0, m_c};
      alu_out      = m_r[7:0];
      alu_flag_out = {m_r[7:0] == 8'h00, 1'b0, m_h[4], m_r[8]};
    end else if (alu_op == ALU_SUB || alu_op == ALU_SBC) begin
      m_c          = (alu_op == ALU_SBC) ? alu_flag_in[0] : 1'b0;
      m_r          = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, m_c};
      m_h          = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'h0, m_c};
      alu_out      = m_r[7:0];
      alu_flag_out = {m_r[7:0] == 8'h00, 1'b1, m_h[4], m_r[8]};
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [3:0]  fin;
    logic [15:0] res;
    logic [3:0]  fl;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  fl;
    int          cyc;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[10];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: each done pops the oldest accepted operation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      sb_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 16'(done), 16'h0);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("flags_out", 16'(flags_out), 16'(e.fl));
        chk("done_latency", 16'(cyc - e.cyc), 16'd3);
      end
    end
  end

  // Reference arithmetic done on whole 16-bit values, not byte passes.
  task automatic model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] fin, output logic [15:0] res, output logic [3:0] fl);
    logic [16:0] s;
    logic [12:0] s12;
    logic [4:0]  h4;
    logic [8:0]  c8;
    case (op)
      2'd0: begin
        s   = {1'b0, a} + {1'b0, b};
        s12 = {1'b0, a[11:0]} + {1'b0, b[11:0]};
        res = s[15:0];
        fl  = {fin[3], 1'b0, s12[12], s[16]};
      end
      2'd1: begin
        h4  = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        c8  = {1'b0, a[7:0]} + {1'b0, b[7:0]};
        res = a + {{8{b[7]}}, b[7:0]};
        fl  = {2'b00, h4[4], c8[8]};
      end
      2'd2:    begin res = a + 16'h1; fl = fin; end
      default: begin res = a - 16'h1; fl = fin; end
    endcase
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] fin, input logic [15:0] res, input logic [3:0] fl);
    op16 = op; opa = a; opb = b; flags_in = fin; start = 1'b1;
    sb.push_back('{res: res, fl: fl, cyc: cyc});
    @(negedge clk);
    start = 1'b0;
    opa = ~a; opb = ~b; flags_in = ~fin; op16 = op ^ 2'b01;
    chk("busy_lo", 16'(busy), 16'd1);
    chk("lo_flag_in_c", 16'(alu_flag_in[0]), 16'd0);
    @(negedge clk);
    chk("busy_hi", 16'(busy), 16'd1);
    @(negedge clk);
    chk("busy_done", 16'(busy), 16'd0);
    chk("done_alu_op", 16'(alu_op), 16'(ALU_COPY_A));
    chk("done_alu_ab", {alu_a, alu_b}, 16'h0000);
    @(negedge clk);
    chk("idle_done_low", 16'(done), 16'd0);
    chk("hold_result", result, res);
    chk("hold_flags", 16'(flags_out), 16'(fl));
    chk("sb_drained", 16'(sb.size()), 16'd0);
    sb.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [15:0] er, ra, rb;
    logic [3:0]  ef, rf;
    logic [1:0]  rop;

    tbl[0] = '{2'd0, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010};
    tbl[1] = '{2'd0, 16'h8000, 16'h8000, 4'b0000, 16'h0000, 4'b0001};
    tbl[2] = '{2'd1, 16'h0005, 16'h00FE, 4'b0000, 16'h0003, 4'b0011};
    tbl[3] = '{2'd1, 16'hFFF8, 16'h0008, 4'b1111, 16'h0000, 4'b0011};
    tbl[4] = '{2'd3, 16'h0000, 16'hABCD, 4'b0101, 16'hFFFF, 4'b0101};
    tbl[5] = '{2'd2, 16'hFFFF, 16'h0000, 4'b1010, 16'h0000, 4'b1010};
    tbl[6] = '{2'd0, 16'h1234, 16'h1111, 4'b0100, 16'h2345, 4'b0000};
    tbl[7] = '{2'd1, 16'h1000, 16'h0080, 4'b1100, 16'h0F80, 4'b0000};
    tbl[8] = '{2'd3, 16'h1000, 16'h5555, 4'b1110, 16'h0FFF, 4'b1110};
    tbl[9] = '{2'd2, 16'h00FF, 16'h0000, 4'b0100, 16'h0100, 4'b0100};

    reset_n = 1'b0; start = 1'b0; op16 = 2'd0; opa = '0; opb = '0; flags_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_result", result, 16'h0000);
    chk("rst_flags", 16'(flags_out), 16'd0);
    chk("rst_alu_op", 16'(alu_op), 16'(ALU_COPY_A));
    chk("rst_alu_flag_in", 16'(alu_flag_in), 16'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].fin, tbl[i].res, tbl[i].fl);

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rf  = 4'($urandom);
      model(rop, ra, rb, rf, er, ef);
      run_op(rop, ra, rb, rf, er, ef);
    end

    // start held through LO and HI is ignored: one done, first operands kept
    d0 = done_cnt;
    op16 = 2'd2; opa = 16'h7FFF; opb = 16'h0000; flags_in = 4'b0011; start = 1'b1;
    sb.push_back('{res: 16'h8000, fl: 4'b0011, cyc: cyc});
    @(negedge clk);
    op16 = 2'd3; opa = 16'h1234; flags_in = 4'b1100;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("ignore_single_done", 16'(done_cnt - d0), 16'd1);
    chk("ignore_sb_empty", 16'(sb.size()), 16'd0);
    sb.delete();

    // start while DONE chains straight into the next operation
    d0 = done_cnt;
    op16 = 2'd0; opa = 16'h00FF; opb = 16'h0001; flags_in = 4'b0000; start = 1'b1;
    sb.push_back('{res: 16'h0100, fl: 4'b0000, cyc: cyc});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done_a", 16'(done), 16'd1);
    op16 = 2'd3; opa = 16'h0100; opb = 16'h0000; flags_in = 4'b1000; start = 1'b1;
    sb.push_back('{res: 16'h00FF, fl: 4'b1000, cyc: cyc});
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 16'(busy), 16'd1);
    repeat (3) @(negedge clk);
    chk("b2b_two_dones", 16'(done_cnt - d0), 16'd2);
    chk("b2b_sb_empty", 16'(sb.size()), 16'd0);
    sb.delete();

    // reset during HI aborts with no done pulse
    d0 = done_cnt;
    op16 = 2'd0; opa = 16'h1234; opb = 16'h4321; flags_in = 4'b1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_result", result, 16'h0000);
    chk("abort_flags", 16'(flags_out), 16'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_done", 16'(done_cnt - d0), 16'd0);
    chk("abort_result_rel", result, 16'h0000);
    chk("abort_busy_rel", 16'(busy), 16'd0);
    run_op(2'd0, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010);

    repeat (3) @(negedge clk);
    chk("final_sb_empty", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
